// File: rtl/mem_access_ctrl.sv
// RV32I load/store initiator between the MemoryAccess stage and a byte-addressed data RAM
// with a one-cycle registered read port; returns a held, extended response.
module mem_access_ctrl #(
    parameter int unsigned AWIDTH = 14,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_qin,
    output logic [2:0]        ram_we,
    input  logic [DWIDTH-1:0] ram_qout
);

    localparam int unsigned BW = 8;
    localparam int unsigned HW = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic        wr;
    logic [2:0]  f3;
    logic        illegal_c;
    logic        misaligned_c;
    logic [DWIDTH-1:0] load_fmt_c;

    // Legality of the request presented on the port this cycle
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        if (req_write) begin
            illegal_c = (req_funct3 > 3'd2);
        end else begin
            illegal_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        if (req_funct3[1:0] == 2'b01) begin
            misaligned_c = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned_c = (req_addr[1:0] != 2'b00);
        end
    end

    // RAM returns the addressed byte in [7:0]; only extension is needed here
    always_comb begin
        load_fmt_c = ram_qout;
        case (f3)
            3'b000:  load_fmt_c = {{(DWIDTH-BW){ram_qout[BW-1]}}, ram_qout[BW-1:0]};
            3'b001:  load_fmt_c = {{(DWIDTH-HW){ram_qout[HW-1]}}, ram_qout[HW-1:0]};
            3'b100:  load_fmt_c = {{(DWIDTH-BW){1'b0}}, ram_qout[BW-1:0]};
            3'b101:  load_fmt_c = {{(DWIDTH-HW){1'b0}}, ram_qout[HW-1:0]};
            default: load_fmt_c = ram_qout;
        endcase
    end

    // Transaction sequencer; every port output is a register of this block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr        <= 1'b0;
            f3        <= 3'b000;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_addr  <= '0;
            ram_qin   <= '0;
            ram_we    <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr        <= req_write;
                        f3        <= req_funct3;
                        ram_addr  <= req_addr;
                        ram_qin   <= req_wdata;
                        req_ready <= 1'b0;
                        if (illegal_c || misaligned_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state  <= ISSUE;
                            ram_we <= req_write ? {1'b1, req_funct3[1:0]} : 3'b000;
                        end
                    end
                end
                ISSUE: begin
                    ram_we <= 3'b000;
                    if (wr) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= load_fmt_c;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    ram_we    <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-array reference model predicts each response,
// a negedge monitor pops and compares on every response handshake.
module tb_mem_access_ctrl;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_qin, ram_qout;
    logic [2:0]    ram_we;

    logic [7:0] ram     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   we_cnt = 0;
    logic [2:0]    last_we;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_qin;

    mem_access_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_qin(ram_qin), .ram_we(ram_we), .ram_qout(ram_qout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered little-endian read, write at the clock edge
    always @(posedge clk) begin
        ram_qout <= {ram[AW'(ram_addr + 3)], ram[AW'(ram_addr + 2)],
                     ram[AW'(ram_addr + 1)], ram[ram_addr]};
        if (ram_we[2]) begin
            ram[ram_addr] = ram_qin[7:0];
            if (ram_we[1:0] != 2'b00) ram[AW'(ram_addr + 1)] = ram_qin[15:8];
            if (ram_we[1:0] == 2'b10) begin
                ram[AW'(ram_addr + 2)] = ram_qin[23:16];
                ram[AW'(ram_addr + 3)] = ram_qin[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (ram_we != 3'b000) begin
            we_cnt    = we_cnt + 1;
            last_we   = ram_we;
            last_addr = ram_addr;
            last_qin  = ram_qin;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference: RV32I rules applied to a plain byte array
    function automatic exp_t model(input logic w, input logic [2:0] f3,
                                   input logic [AW-1:0] a, input logic [31:0] wd);
        exp_t   r;
        int     nb;
        logic   bad;
        longint v;
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        bad = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if ((int'(a) % nb) != 0) bad = 1'b1;
        r.err   = bad;
        r.rdata = 32'd0;
        if (!bad) begin
            if (w) begin
                for (int i = 0; i < nb; i++) ref_mem[AW'(int'(a) + i)] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v += longint'(ref_mem[AW'(int'(a) + i)]) << (8 * i);
                if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
                r.rdata = 32'(v);
            end
        end
        return r;
    endfunction

    // Monitor: one comparison pair per response handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk = n_chk + 1;
                $display("FAIL rsp_unexpected: got response %h with empty queue", rsp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic do_txn(input logic w, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [31:0] wd, input int hold);
        exp_t e;
        int   guard, lat, exp_lat;
        logic [31:0] rd0;
        e = model(w, f3, a, wd);
        exp_q.push_back(e);
        exp_lat = e.err ? 1 : (w ? 2 : 3);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_chk = n_chk + 1;
            $display("FAIL accept_timeout: req_ready got 0 expected 1");
            req_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = (hold == 0);
        we_cnt = 0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            n_chk = n_chk + 1;
            $display("FAIL rsp_timeout: rsp_valid got 0 expected 1");
            rsp_ready = 1'b0;
            return;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        rd0 = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, rd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
        check("we_cycles", 32'(we_cnt), (w && !e.err) ? 32'd1 : 32'd0);
        if (w && !e.err) begin
            check("we_value", 32'(last_we), 32'({1'b1, f3[1:0]}));
            check("we_addr", 32'(last_addr), 32'(a));
            check("we_qin", last_qin, wd);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_qin", ram_qin, 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        #22;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Store/load basics and extension
        do_txn(1'b1, 3'b010, 14'h010, 32'h8765_4321, 0);
        do_txn(1'b0, 3'b010, 14'h010, 32'h0, 0);
        do_txn(1'b0, 3'b000, 14'h013, 32'h0, 0);
        do_txn(1'b0, 3'b100, 14'h013, 32'h0, 0);
        do_txn(1'b0, 3'b001, 14'h012, 32'h0, 0);
        do_txn(1'b0, 3'b101, 14'h010, 32'h0, 0);
        do_txn(1'b1, 3'b000, 14'h011, 32'hFFFF_FFAA, 0);
        do_txn(1'b0, 3'b010, 14'h010, 32'h0, 0);
        // Errors
        do_txn(1'b0, 3'b010, 14'h012, 32'h0, 0);
        do_txn(1'b1, 3'b001, 14'h011, 32'h1234_5678, 0);
        do_txn(1'b0, 3'b011, 14'h010, 32'h0, 0);
        // Back-pressured load response
        do_txn(1'b0, 3'b010, 14'h010, 32'h0, 5);

        // Reset during the ISSUE cycle of a store drops it
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 14'h020; req_wdata = 32'hDEAD_BEEF;
        for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("issue_we", 32'(ram_we), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 3'b010, 14'h020, 32'h0, 0);

        // Randomized traffic over a small window so loads hit earlier stores
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] ra;
            ra = AW'(14'h100 + $urandom_range(0, 63));
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
                   $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator that sits between the MemoryAccess pipeline stage and the byte-addressed data RAM. It accepts one RV32I load/store request per transaction over a valid/ready handshake and drives the RAM's addr/qin/we port. For loads it waits out the RAM's one-cycle registered read latency, then byte/halfword-extracts and sign/zero-extends the data. It returns a held response, with an error flag for misaligned or illegal accesses.

## Interface
- AWIDTH, 14: byte-address width, matches the RAM addr port
- DWIDTH, 32: data width; RV32I only
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  AWIDTH  byte address
- req_wdata  in  DWIDTH  store data, right-justified
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DWIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3
- ram_addr  out  AWIDTH  RAM byte address
- ram_qin  out  DWIDTH  RAM write data
- ram_we  out  3  RAM write enable: bit2 = write, [1:0] = size (00 byte, 01 half, 10 word); 3'b000 = no write
- ram_qout  in  DWIDTH  RAM read data; registered, valid the cycle after ram_addr is presented; little-endian, byte at ram_addr in [7:0]

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, funct3, addr and wdata.
  - If the access is illegal or misaligned, go to RESP with err=1 and rdata=0.
  - Otherwise go to ISSUE.
- Illegal accesses:
  - Load with funct3 in {011, 110, 111}.
  - Store with funct3 not in {000, 001, 010}.
- Misaligned accesses:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Byte accesses are never misaligned.
- ISSUE:
  - ram_addr = latched addr.
  - Store: ram_we = {1, funct3[1:0]} and ram_qin = latched wdata, unshifted; the RAM writes at the end of this cycle. Next state RESP, rdata=0, err=0.
  - Load: ram_we = 3'b000. Next state WAIT.
- WAIT:
  - ram_addr is still held.
  - ram_qout is valid; capture the formatted value into the rsp_rdata register. Next state RESP.
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: [31:0].
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE; rsp_valid deasserts the next cycle.
  - req_ready=0 in every state except IDLE.
- ram_we is decoded from the state register and is 3'b000 in every state except ISSUE-with-store.
- ram_addr and ram_qin hold their last latched values outside ISSUE/WAIT. The RAM does not write while ram_we=000.
- Reset (asynchronous, including mid-transaction):
  - State returns to IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_addr=0, ram_qin=0, ram_we=000.
  - ram_we drops immediately, so no partial write completes after reset assertion.
  - An in-flight request is dropped with no response.

## Timing
- Cycle 0 is the accept edge (req_valid & req_ready in IDLE).
- Load: ISSUE in cycle 1, WAIT in cycle 2, rsp_valid from cycle 3. Latency 3.
- Store: ISSUE in cycle 1 with the RAM write at the end of cycle 1; rsp_valid from cycle 2.
- Error: rsp_valid from cycle 1, with no RAM access.
- Minimum spacing between accepts:
  - Load: 4 cycles.
  - Store: 3 cycles.
  - Error: 2 cycles.
  - Each extra cycle of rsp_ready low adds 1.
- Load after store to the same address returns the stored data: the store's write completes before the load's ISSUE.
- If rsp_ready is already high on entry to RESP, the response lasts exactly one cycle.

## Test plan
- SW addr 0x010, wdata 0x8765_4321 -> ram_we=3'b110 for exactly one cycle; rsp_valid at accept+2, rsp_err=0. Then LW 0x010 -> rsp_rdata=0x8765_4321 at accept+3.
- After the store above:
  - LB 0x013 -> 0xFFFF_FF87.
  - LBU 0x013 -> 0x0000_0087.
  - LH 0x012 -> 0xFFFF_8765.
  - LHU 0x010 -> 0x0000_4321.
- SB 0x011 with wdata 0xFFFF_FFAA, then LW 0x010 -> 0x8765_AA21 (only one byte written, ram_we=3'b100).
- Error cases, each giving rsp_err=1, rsp_rdata=0, rsp_valid at accept+1, and ram_we never nonzero:
  - LW 0x012.
  - SH 0x011.
  - Load funct3=011.
- Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata are stable, req_ready stays 0, and a pending req_valid is not accepted until the cycle after the rsp_ready handshake.
- Assert rst_n low during the ISSUE cycle of SW 0x020 -> ram_we goes to 000 asynchronously, and a subsequent LW 0x020 returns the pre-store value (0). Outputs match their reset values while rst_n=0.
